exec_mem_unit: RTL and testbench

Execute/memory stage of the 8-bit single-cycle processor. It contains a combinational ALU, a combinational 8-bit barrel shifter, and a data memory addressed by the ALU result. It also holds the registered carry (C) and zero (Z) flags. The register file and control unit sit outside this block; it returns one selected write-back result.

---
 rtl/exec_mem_unit_pkg.sv | 23 ++
 rtl/exec_barrel_shifter.sv | 55 +++++
 rtl/exec_mem_unit.sv | 102 ++++++++++
 tb/tb_exec_mem_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_mem_unit_pkg.sv
// Shared constants for the execute/memory stage.
// Opcodes, write-back selects and datapath width.
package exec_mem_unit_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ADC   = 3'b001,
    OP_SUB   = 3'b010,
    OP_SBC   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_SHIFT = 2'b01;
  localparam logic [1:0] RES_MEM   = 2'b10;
  localparam logic [1:0] RES_ALU2  = 2'b11;

endpackage

// File: rtl/exec_barrel_shifter.sv
// Combinational 8-bit barrel shifter.
// Logical shift or rotate, left or right, with carry/zero.
module exec_barrel_shifter
  import exec_mem_unit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [2:0]        count,
  input  logic              dir,
  input  logic              mode,
  output logic [DATA_W-1:0] out,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0]   sl;
  logic [DATA_W:0]   sr;
  logic [DATA_W-1:0] rl;
  logic [DATA_W-1:0] rr;
  logic [3:0]        inv;

  // Extra bit catches the last bit shifted out
  assign sl  = {1'b0, a} << count;
  assign sr  = {a, 1'b0} >> count;
  assign inv = 4'd8 - {1'b0, count};
  assign rl  = (a << count) | (a >> inv);
  assign rr  = (a >> count) | (a << inv);

  always_comb begin
    out = a;
    c   = 1'b0;
    if (count != 3'd0) begin
      unique case (1'b1)
        (mode && !dir): begin
          out = sl[DATA_W-1:0];
          c   = sl[DATA_W];
        end
        (mode && dir): begin
          out = sr[DATA_W:1];
          c   = sr[0];
        end
        (!mode && !dir): begin
          out = rl;
          c   = rl[0];
        end
        default: begin
          out = rr;
          c   = rr[DATA_W-1];
        end
      endcase
    end
  end

  assign z = (out == '0);

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: ALU, barrel shifter, data memory,
// registered C/Z flags and write-back result select.
module exec_mem_unit
  import exec_mem_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic              alu_use_carry,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        shift_count,
  input  logic              shift_dir,
  input  logic              shift_mode,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        res_sel,
  input  logic              select_c,
  input  logic              select_z,
  input  logic              write_c,
  input  logic              write_z,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] shift_out,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] result,
  output logic              c_flag,
  output logic              z_flag
);

  logic              cin;
  logic [DATA_W:0]   sum;
  logic              alu_co;
  logic              alu_z;
  logic              shift_c;
  logic              shift_z;
  logic [ADDR_W-1:0] addr;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign cin = alu_use_carry & c_flag;

  // Bit 8 of the 9-bit difference is the borrow
  always_comb begin
    sum = '0;
    unique case (alu_op_e'(alu_op))
      OP_ADD:   sum = {1'b0, a} + {1'b0, b};
      OP_ADC:   sum = {1'b0, a} + {1'b0, b}
                      + {{DATA_W{1'b0}}, cin};
      OP_SUB:   sum = {1'b0, a} - {1'b0, b};
      OP_SBC:   sum = {1'b0, a} - {1'b0, b}
                      - {{DATA_W{1'b0}}, cin};
      OP_AND:   sum = {1'b0, a & b};
      OP_OR:    sum = {1'b0, a | b};
      OP_XOR:   sum = {1'b0, a ^ b};
      default:  sum = {1'b0, b};
    endcase
  end

  assign alu_out = sum[DATA_W-1:0];
  assign alu_co  = sum[DATA_W];
  assign alu_z   = (alu_out == '0);

  exec_barrel_shifter u_shift (
    .a     (a),
    .count (shift_count),
    .dir   (shift_dir),
    .mode  (shift_mode),
    .out   (shift_out),
    .c     (shift_c),
    .z     (shift_z)
  );

  assign addr      = alu_out[ADDR_W-1:0];
  assign mem_rdata = mem[addr];

  // Memory is deliberately not gated by reset
  always_ff @(posedge clk) begin
    if (mem_write) mem[addr] <= mem_wdata;
  end

  always_comb begin
    result = alu_out;
    case (res_sel)
      RES_SHIFT: result = shift_out;
      RES_MEM:   result = mem_rdata;
      default:   result = alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (write_c) c_flag <= select_c ? shift_c : alu_co;
      if (write_z) z_flag <= select_z ? shift_z : alu_z;
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed cases
// followed by random stimulus against an arithmetic model.
module tb_exec_mem_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic       alu_use_carry;
  logic [7:0] a, b;
  logic [2:0] shift_count;
  logic       shift_dir, shift_mode;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [1:0] res_sel;
  logic       select_c, select_z;
  logic       write_c, write_z;
  logic [7:0] alu_out, shift_out, mem_rdata, result;
  logic       c_flag, z_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       mc, mz;
  bit [7:0] mm [256];
  bit       mv [256];

  exec_mem_unit #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .alu_op(alu_op), .alu_use_carry(alu_use_carry),
    .a(a), .b(b),
    .shift_count(shift_count), .shift_dir(shift_dir),
    .shift_mode(shift_mode),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .res_sel(res_sel),
    .select_c(select_c), .select_z(select_z),
    .write_c(write_c), .write_z(write_z),
    .alu_out(alu_out), .shift_out(shift_out),
    .mem_rdata(mem_rdata), .result(result),
    .c_flag(c_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_alu(output int o, output bit co);
    int ai, bi, ci, s;
    ai = a; bi = b;
    ci = (alu_use_carry && mc) ? 1 : 0;
    co = 0;
    case (alu_op)
      3'd0: begin s = ai + bi;      co = s > 255; end
      3'd1: begin s = ai + bi + ci; co = s > 255; end
      3'd2: begin s = ai - bi;      co = ai < bi; end
      3'd3: begin s = ai - bi - ci; co = ai < bi + ci; end
      3'd4: s = ai & bi;
      3'd5: s = ai | bi;
      3'd6: s = ai ^ bi;
      default: s = bi;
    endcase
    o = s & 255;
  endfunction

  function automatic void model_sh(output int o, output bit c);
    int n, v;
    n = shift_count; v = a; c = 0;
    if (n == 0) o = v;
    else if (shift_mode) begin
      if (!shift_dir) begin
        o = (v << n) & 255; c = ((v >> (8 - n)) & 1) != 0;
      end else begin
        o = v >> n;         c = ((v >> (n - 1)) & 1) != 0;
      end
    end else begin
      for (int i = 0; i < n; i++)
        if (!shift_dir) v = ((v << 1) & 255) | (v >> 7);
        else            v = (v >> 1) | ((v & 1) << 7);
      o = v;
      c = shift_dir ? ((v >> 7) & 1) != 0 : (v & 1) != 0;
    end
  endfunction

  // Check combinational outputs, clock once, check flags
  task automatic cycle();
    int ao, so, ad;
    bit co, sc;
    logic [7:0] er;
    #1;
    model_alu(ao, co);
    model_sh(so, sc);
    ad = ao;
    chk("alu_out", alu_out, 8'(ao));
    chk("shift_out", shift_out, 8'(so));
    if (mv[ad]) chk("mem_rdata", mem_rdata, mm[ad]);
    case (res_sel)
      2'd1:    er = 8'(so);
      2'd2:    er = mv[ad] ? mm[ad] : 8'hxx;
      default: er = 8'(ao);
    endcase
    if (res_sel != 2'd2 || mv[ad]) chk("result", result, er);
    @(posedge clk);
    if (!reset) begin
      mc = 0; mz = 0;
    end else begin
      if (write_c) mc = select_c ? sc : co;
      if (write_z) mz = select_z ? (so == 0) : (ao == 0);
    end
    if (mem_write) begin
      mm[ad] = mem_wdata; mv[ad] = 1;
    end
    #1;
    chk("c_flag", {7'b0, c_flag}, {7'b0, mc});
    chk("z_flag", {7'b0, z_flag}, {7'b0, mz});
  endtask

  typedef struct {
    logic [2:0] n; logic d; logic m;
    logic [7:0] o; logic c;
  } sh_vec_t;

  sh_vec_t sv [5];

  initial begin
    sv[0] = '{3'd3, 1'b0, 1'b1, 8'hB0, 1'b0};
    sv[1] = '{3'd2, 1'b1, 1'b1, 8'h25, 1'b1};
    sv[2] = '{3'd1, 1'b0, 1'b0, 8'h2D, 1'b1};
    sv[3] = '{3'd4, 1'b1, 1'b0, 8'h69, 1'b0};
    sv[4] = '{3'd0, 1'b0, 1'b1, 8'h96, 1'b0};

    reset = 0; alu_op = 3'd0; alu_use_carry = 0;
    a = 8'hFF; b = 8'h01;
    shift_count = 0; shift_dir = 0; shift_mode = 1;
    mem_write = 0; mem_wdata = 0; res_sel = 0;
    select_c = 0; select_z = 0; write_c = 1; write_z = 1;

    cycle();
    chk("rst_c", {7'b0, c_flag}, 8'h00);
    chk("rst_z", {7'b0, z_flag}, 8'h00);

    reset = 1;
    #1 chk("add_ff", alu_out, 8'h00);
    cycle();
    chk("add_c", {7'b0, c_flag}, 8'h01);
    chk("add_z", {7'b0, z_flag}, 8'h01);

    alu_op = 3'd1; alu_use_carry = 1; a = 8'h10; b = 8'h20;
    #1 chk("adc", alu_out, 8'h31);
    cycle();
    chk("adc_c", {7'b0, c_flag}, 8'h00);
    chk("adc_z", {7'b0, z_flag}, 8'h00);

    alu_op = 3'd2; alu_use_carry = 0; a = 8'h05; b = 8'h07;
    #1 chk("sub", alu_out, 8'hFE);
    cycle();
    chk("sub_c", {7'b0, c_flag}, 8'h01);
    a = 8'h07;
    #1 chk("sub_eq", alu_out, 8'h00);
    cycle();
    chk("sub_eq_c", {7'b0, c_flag}, 8'h00);
    chk("sub_eq_z", {7'b0, z_flag}, 8'h01);

    a = 8'h96; select_c = 1; write_z = 0;
    foreach (sv[i]) begin
      shift_count = sv[i].n; shift_dir = sv[i].d;
      shift_mode = sv[i].m;
      #1 chk("shift", shift_out, sv[i].o);
      cycle();
      chk("shift_c", {7'b0, c_flag}, {7'b0, sv[i].c});
    end

    select_c = 0; write_c = 0; alu_op = 3'd7;
    mem_write = 1; b = 8'h15; mem_wdata = 8'h5A;
    cycle();
    b = 8'h16; mem_wdata = 8'h3C;
    cycle();
    alu_op = 3'd0; a = 8'h10; b = 8'h05; mem_wdata = 8'hAB;
    #1 chk("mem_old", mem_rdata, 8'h5A);
    cycle();
    mem_write = 0; res_sel = 2'd2;
    #1 chk("mem_new", mem_rdata, 8'hAB);
    chk("res_mem", result, 8'hAB);
    cycle();
    alu_op = 3'd7; b = 8'h16;
    #1 chk("mem_other", mem_rdata, 8'h3C);
    cycle();

    res_sel = 0; alu_op = 3'd0;
    write_c = 1; write_z = 1; a = 8'h01; b = 8'h01;
    cycle();
    write_c = 0; a = 8'hFF; b = 8'h01;
    cycle();
    chk("hold_c0", {7'b0, c_flag}, 8'h00);
    chk("z_set", {7'b0, z_flag}, 8'h01);
    b = 8'h02;
    cycle();
    chk("hold_c1", {7'b0, c_flag}, 8'h00);
    chk("z_clr", {7'b0, z_flag}, 8'h00);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 19) != 0);
      alu_op = 3'($urandom);
      alu_use_carry = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      shift_count = 3'($urandom);
      shift_dir = 1'($urandom);
      shift_mode = 1'($urandom);
      mem_write = 1'($urandom);
      mem_wdata = 8'($urandom);
      res_sel = 2'($urandom);
      select_c = 1'($urandom); select_z = 1'($urandom);
      write_c = 1'($urandom); write_z = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
